bdd_walk_engine: RTL and testbench



---
 rtl/bdd_pkg.sv | 42 ++++
 rtl/bdd_node_ram.sv | 20 ++
 rtl/bdd_walk_engine.sv | 124 ++++++++++++
 tb/tb_bdd_walk_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared geometry, node/child encodings and FSM states for the BDD walk engine.
package bdd_pkg;

  localparam int unsigned IN_W      = 1894;
  localparam int unsigned NODES     = 256;
  localparam int unsigned NUM_OUT   = 64;
  localparam int unsigned MAX_STEPS = 64;

  localparam int unsigned VAR_W   = $clog2(IN_W);
  localparam int unsigned PTR_W   = $clog2(NODES);
  localparam int unsigned CHILD_W = PTR_W + 1;
  localparam int unsigned SEL_W   = $clog2(NUM_OUT);
  localparam int unsigned STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int unsigned NODE_W  = VAR_W + 2 * CHILD_W;

  // MSB set marks a terminal whose value is the LSB; otherwise low bits are a node pointer.
  typedef logic [CHILD_W-1:0] child_t;

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    child_t           lo;
    child_t           hi;
  } node_t;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  localparam child_t TERM_0 = {1'b1, {PTR_W{1'b0}}};
  localparam child_t TERM_1 = {1'b1, {(PTR_W-1){1'b0}}, 1'b1};

  function automatic logic is_term(input child_t c);
    return c[CHILD_W-1];
  endfunction

  function automatic logic term_val(input child_t c);
    return c[0];
  endfunction

  function automatic logic [PTR_W-1:0] child_ptr(input child_t c);
    return c[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/bdd_node_ram.sv
// Node table: one write port, one synchronous read port, contents not reset.
module bdd_node_ram
  import bdd_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  node_t            wdata,
  input  logic [PTR_W-1:0] raddr,
  output node_t            rdata
);

  node_t mem [NODES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bdd_walk_engine.sv
// Table-driven BDD evaluator: walks from a root pointer one node per FETCH/EVAL pair.
module bdd_walk_engine
  import bdd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tbl_we,
  input  logic [PTR_W-1:0]   tbl_addr,
  input  logic [NODE_W-1:0]  tbl_data,
  input  logic               root_we,
  input  logic [SEL_W-1:0]   root_sel,
  input  logic [CHILD_W-1:0] root_data,
  output logic               cfg_ready,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_out,
  input  logic [IN_W-1:0]    req_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_bit,
  output logic               res_err,
  output logic [STEP_W-1:0]  res_steps
);

  state_t            state;
  logic              rdy_q;
  child_t            root_q [NUM_OUT];
  logic [PTR_W-1:0]  cur_ptr;
  logic [IN_W-1:0]   vec_q;
  logic [STEP_W-1:0] step_q;
  node_t             node_rd;
  child_t            root_cur;
  logic              accept;
  logic              var_ok;
  logic              sel_bit;
  child_t            next_c;
  logic [STEP_W-1:0] step_inc;

  assign cfg_ready = rdy_q;
  assign req_ready = rdy_q;
  assign accept    = req_valid && rdy_q;
  assign root_cur  = root_q[req_out];

  bdd_node_ram u_ram (
    .clk   (clk),
    .we    (tbl_we && rdy_q),
    .waddr (tbl_addr),
    .wdata (node_t'(tbl_data)),
    .raddr (cur_ptr),
    .rdata (node_rd)
  );

  always_comb begin
    var_ok   = node_rd.var_idx < VAR_W'(IN_W);
    sel_bit  = var_ok ? vec_q[node_rd.var_idx] : 1'b0;
    next_c   = sel_bit ? node_rd.hi : node_rd.lo;
    step_inc = step_q + 1'b1;
  end

  // Root reads in IDLE see the pre-write value, so a same-cycle root write never affects that request.
  always_ff @(posedge clk) begin
    if (!rst_n) root_q <= '{default: TERM_0};
    else if (root_we && rdy_q) root_q[root_sel] <= root_data;
  end

  always_ff @(posedge clk) begin
    if (accept) vec_q <= req_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_q     <= 1'b1;
      res_valid <= 1'b0;
      res_bit   <= 1'b0;
      res_err   <= 1'b0;
      res_steps <= '0;
      step_q    <= '0;
      cur_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rdy_q   <= 1'b0;
            step_q  <= '0;
            cur_ptr <= child_ptr(root_cur);
            if (is_term(root_cur)) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_bit   <= term_val(root_cur);
              res_err   <= 1'b0;
              res_steps <= '0;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: state <= EVAL;
        EVAL: begin
          step_q <= step_inc;
          if (!var_ok || is_term(next_c) || step_inc == STEP_W'(MAX_STEPS)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_bit   <= var_ok && is_term(next_c) && term_val(next_c);
            res_err   <= !var_ok || !is_term(next_c);
            res_steps <= step_inc;
          end else begin
            cur_ptr <= child_ptr(next_c);
            state   <= FETCH;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            rdy_q     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_walk_engine.sv
// Self-checking bench for bdd_walk_engine with directed scenarios and a randomized DAG walk.
module tb_bdd_walk_engine;
  import bdd_pkg::*;

  typedef logic [24:0] res_t;  // {bit, err, steps[6:0], latency[15:0]}

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tbl_we;
  logic [PTR_W-1:0]   tbl_addr;
  logic [NODE_W-1:0]  tbl_data;
  logic               root_we;
  logic [SEL_W-1:0]   root_sel;
  logic [CHILD_W-1:0] root_data;
  logic               cfg_ready;
  logic               req_valid;
  logic               req_ready;
  logic [SEL_W-1:0]   req_out;
  logic [IN_W-1:0]    req_vec;
  logic               res_valid;
  logic               res_ready;
  logic               res_bit;
  logic               res_err;
  logic [STEP_W-1:0]  res_steps;

  int n_checks = 0;
  int n_fail   = 0;

  node_t  mdl_node [NODES];
  child_t mdl_root [NUM_OUT];

  always #5 clk = ~clk;

  bdd_walk_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .root_we   (root_we),
    .root_sel  (root_sel),
    .root_data (root_data),
    .cfg_ready (cfg_ready),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_out   (req_out),
    .req_vec   (req_vec),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bit   (res_bit),
    .res_err   (res_err),
    .res_steps (res_steps)
  );

  function automatic res_t mk(input logic b, input logic e, input int s, input int lat);
    return {b, e, STEP_W'(s), 16'(lat)};
  endfunction

  function automatic string res_str(input res_t r);
    return $sformatf("bit=%0b err=%0b steps=%0d lat=%0d", r[24], r[23], r[22:16], r[15:0]);
  endfunction

  function automatic child_t ptr_c(input int p);
    return {1'b0, PTR_W'(p)};
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < int'(IN_W); i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Reference walk: follow children from the root until a terminal, a bad variable or the step cap.
  function automatic res_t model_eval(input logic [IN_W-1:0] v, input int o);
    child_t c = mdl_root[o];
    node_t  n;
    if (c[CHILD_W-1]) return mk(c[0], 1'b0, 0, 1);
    for (int s = 1; s <= int'(MAX_STEPS); s++) begin
      n = mdl_node[c[PTR_W-1:0]];
      if (int'(n.var_idx) >= int'(IN_W)) return mk(1'b0, 1'b1, s, 2*s + 1);
      c = v[n.var_idx] ? n.hi : n.lo;
      if (c[CHILD_W-1]) return mk(c[0], 1'b0, s, 2*s + 1);
    end
    return mk(1'b0, 1'b1, MAX_STEPS, 2*MAX_STEPS + 1);
  endfunction

  task automatic write_node(input int a, input int v, input child_t lo, input child_t hi);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = PTR_W'(a); tbl_data = {VAR_W'(v), lo, hi};
    @(posedge clk); #1;
    tbl_we = 1'b0;
    mdl_node[a] = {VAR_W'(v), lo, hi};
  endtask

  task automatic write_root(input int sel, input child_t c);
    @(negedge clk);
    root_we = 1'b1; root_sel = SEL_W'(sel); root_data = c;
    @(posedge clk); #1;
    root_we = 1'b0;
    mdl_root[sel] = c;
  endtask

  // Drives one request (optionally with a simultaneous root write) and completes the handshake.
  task automatic do_req(input int o, input logic [IN_W-1:0] v, input logic rw, input int rsel,
                        input child_t rdat, output res_t r);
    int lat;
    @(negedge clk);
    req_out = SEL_W'(o); req_vec = v; req_valid = 1'b1;
    root_we = rw; root_sel = SEL_W'(rsel); root_data = rdat;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; root_we = 1'b0;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL res_timeout: got res_valid=%b expected 1 within 400 cycles", res_valid);
    end
    r = {res_bit, res_err, res_steps, 16'(lat)};
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL release: got valid/ready=%b expected 01", {res_valid, req_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tbl_we = 1'b0; root_we = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    tbl_addr = '0; tbl_data = '0; root_sel = '0; root_data = '0; req_out = '0; req_vec = '0;
    for (int i = 0; i < int'(NUM_OUT); i++) mdl_root[i] = TERM_0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, cfg_ready, res_valid} !== 3'b110) begin
      n_fail++; $display("FAIL reset_hs: got rdy/cfg/valid=%b expected 110", {req_ready, cfg_ready, res_valid});
    end
    n_checks++;
    if ({res_bit, res_err, res_steps} !== '0) begin
      n_fail++; $display("FAIL reset_res: got bit=%b err=%b steps=%0d expected all 0", res_bit, res_err, res_steps);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_terminal_root();
    res_t r;
    do_req(7, rand_vec(), 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b0, 0, 1)) begin
      n_fail++; $display("FAIL reset_root_t0: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b0, 0, 1)));
    end
    write_root(5, TERM_1);
    do_req(5, rand_vec(), 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 0, 1)) begin
      n_fail++; $display("FAIL terminal_root: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 0, 1)));
    end
  endtask

  task automatic test_single_node();
    res_t r;
    logic [IN_W-1:0] v;
    write_node(0, 63, TERM_0, TERM_1);
    write_root(0, ptr_c(0));
    v = rand_vec(); v[63] = 1'b1;
    do_req(0, v, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 1, 3)) begin
      n_fail++; $display("FAIL single_hi: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 1, 3)));
    end
    v[63] = 1'b0;
    do_req(0, v, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b0, 1, 3)) begin
      n_fail++; $display("FAIL single_lo: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b0, 1, 3)));
    end
  endtask

  task automatic test_chain();
    res_t r;
    logic [IN_W-1:0] v;
    write_node(1, 1713, TERM_0, ptr_c(2));
    write_node(2, 1714, TERM_0, ptr_c(3));
    write_node(3, 1715, TERM_0, TERM_1);
    write_root(1, ptr_c(1));
    v = '1;
    do_req(1, v, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 3, 7)) begin
      n_fail++; $display("FAIL chain_hi: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 3, 7)));
    end
    v[1714] = 1'b0;
    do_req(1, v, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b0, 2, 5)) begin
      n_fail++; $display("FAIL chain_lo: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b0, 2, 5)));
    end
  endtask

  task automatic test_self_loop();
    res_t r;
    write_node(10, 0, ptr_c(10), ptr_c(10));
    write_root(2, ptr_c(10));
    do_req(2, rand_vec(), 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b1, 64, 129)) begin
      n_fail++; $display("FAIL self_loop: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b1, 64, 129)));
    end
  endtask

  task automatic test_bad_var_hold();
    res_t r;
    int lat;
    logic [IN_W-1:0] v;
    write_node(20, 2000, TERM_1, TERM_1);
    write_root(3, ptr_c(20));
    @(negedge clk);
    req_out = SEL_W'(3); req_vec = rand_vec(); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Writes attempted mid-walk must be dropped.
    tbl_we = 1'b1; tbl_addr = '0; tbl_data = {VAR_W'(63), TERM_1, TERM_0};
    root_we = 1'b1; root_sel = '0; root_data = TERM_1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL cfg_ready_busy: got %b expected 0", cfg_ready);
    end
    @(posedge clk); #1;
    tbl_we = 1'b0; root_we = 1'b0;
    lat = 2;
    while (res_valid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {res_bit, res_err, res_steps, 16'(lat)};
    n_checks++;
    if (r !== mk(1'b0, 1'b1, 1, 3)) begin
      n_fail++; $display("FAIL bad_var: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b1, 1, 3)));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({res_valid, res_bit, res_err, res_steps, req_ready, cfg_ready} !== {1'b1, 1'b0, 1'b1, 7'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_c%0d: got valid=%b bit=%b err=%b steps=%0d rdy=%b cfg=%b expected 1 0 1 1 0 0",
                 c, res_valid, res_bit, res_err, res_steps, req_ready, cfg_ready);
      end
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    v = rand_vec(); v[63] = 1'b1;
    do_req(0, v, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 1, 3)) begin
      n_fail++; $display("FAIL dropped_writes: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 1, 3)));
    end
  endtask

  task automatic test_root_race();
    res_t r;
    write_root(6, TERM_1);
    do_req(6, rand_vec(), 1'b1, 6, TERM_0, r);
    mdl_root[6] = TERM_0;
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 0, 1)) begin
      n_fail++; $display("FAIL race_old_root: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 0, 1)));
    end
    do_req(6, rand_vec(), 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b0, 0, 1)) begin
      n_fail++; $display("FAIL race_new_root: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b0, 0, 1)));
    end
  endtask

  task automatic test_reset_mid_walk();
    res_t r;
    @(negedge clk);
    req_out = SEL_W'(1); req_vec = '1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(NUM_OUT); i++) mdl_root[i] = TERM_0;
    n_checks++;
    if ({res_valid, req_ready, cfg_ready} !== 3'b011) begin
      n_fail++; $display("FAIL mid_reset: got valid/rdy/cfg=%b expected 011", {res_valid, req_ready, cfg_ready});
    end
    @(negedge clk); rst_n = 1'b1;
    do_req(1, '1, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b0, 1'b0, 0, 1)) begin
      n_fail++; $display("FAIL root_cleared: got %s expected %s", res_str(r), res_str(mk(1'b0, 1'b0, 0, 1)));
    end
    write_root(1, ptr_c(1));
    do_req(1, '1, 1'b0, 0, TERM_0, r);
    n_checks++;
    if (r !== mk(1'b1, 1'b0, 3, 7)) begin
      n_fail++; $display("FAIL table_kept: got %s expected %s", res_str(r), res_str(mk(1'b1, 1'b0, 3, 7)));
    end
  endtask

  task automatic test_random();
    res_t r, e;
    int o, j;
    logic [IN_W-1:0] v;
    child_t lo, hi;
    for (int i = 100; i < 164; i++) begin
      j = (i < 163) ? $urandom_range(i + 1, 163) : 0;
      lo = (i == 163 || $urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? TERM_1 : TERM_0) : ptr_c(j);
      j = (i < 163) ? $urandom_range(i + 1, 163) : 0;
      hi = (i == 163 || $urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? TERM_1 : TERM_0) : ptr_c(j);
      write_node(i, ($urandom_range(0, 24) == 0) ? $urandom_range(IN_W, 2047) : $urandom_range(0, IN_W - 1), lo, hi);
    end
    for (int s = 10; s < 20; s++)
      write_root(s, ($urandom_range(0, 4) == 0) ? TERM_1 : ptr_c($urandom_range(100, 130)));
    for (int t = 0; t < 24; t++) begin
      o = $urandom_range(10, 19);
      v = rand_vec();
      e = model_eval(v, o);
      do_req(o, v, 1'b0, 0, TERM_0, r);
      n_checks++;
      if (r !== e) begin
        n_fail++; $display("FAIL rand_%0d slot %0d: got %s expected %s", t, o, res_str(r), res_str(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_terminal_root();
    test_single_node();
    test_chain();
    test_self_loop();
    test_bad_var_hold();
    test_root_race();
    test_reset_mid_walk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
